// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// The FSM state encoding, the error counter width and an unsigned absolute difference.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;

  // Larger minus smaller, so the result never underflows.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/clk_mon_edge_det.sv
// Optional synchronizer for the divided clock, followed by rising-edge detection.
// With SYNC_STAGES == 0 the input is treated as already synchronous to clk.
module clk_mon_edge_det #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic s_d;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s = sig_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync <= '0;
        end else begin
          sync[0] <= sig_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
      end
      assign s = sync[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s;
  end

  assign rise = s & ~s_d;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in source-clock cycles, checks
// both against expectations, tracks lock and counts errors including stuck-clock timeouts.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int EXP_PERIOD  = 3,
  parameter int EXP_HIGH    = 1,
  parameter int TOL         = 0,
  parameter int LOCK_N      = 4,
  parameter int MAX_PERIOD  = 16,
  parameter int SYNC_STAGES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sig_in,
  output logic [CNT_W-1:0]     period_out,
  output logic [CNT_W-1:0]     high_out,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 err,
  output logic                 timeout,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);
  localparam logic [3:0]       LOCK_V = 4'(LOCK_N);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] v);
    return (v != '1) ? v + 1'b1 : v;
  endfunction

  logic             s;
  logic             rise;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [3:0]       good_cnt;
  logic             timeout_hit;
  logic             closing;
  logic             good;

  clk_mon_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .s     (s),
    .rise  (rise)
  );

  // A rise on the threshold cycle wins over the timeout; a pending timeout never re-fires.
  always_comb begin
    timeout_hit = (state != IDLE) && !rise && !timeout && (period_cnt == MAX_V);
    closing     = (state == MEAS) && rise;
    good        = (abs_diff(32'(period_cnt), 32'(EXP_PERIOD)) <= 32'(TOL)) &&
                  (abs_diff(32'(high_cnt),   32'(EXP_HIGH))   <= 32'(TOL));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = SEEK;
      SEEK:    if (rise) state_nxt = MEAS;
      MEAS:    if (timeout_hit) state_nxt = SEEK;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      good_cnt   <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      if (!en) begin
        period_cnt <= '0;
        high_cnt   <= '0;
        good_cnt   <= '0;
        locked     <= 1'b0;
        timeout    <= 1'b0;
      end else if (state == IDLE) begin
        period_cnt <= '0;
        high_cnt   <= '0;
      end else if (rise) begin
        // Every rise opens a window; in MEAS it also closes the previous one.
        period_cnt <= ONE_V;
        high_cnt   <= ONE_V;
        timeout    <= 1'b0;
        if (closing) begin
          period_out <= period_cnt;
          high_out   <= high_cnt;
          meas_valid <= 1'b1;
          if (good) begin
            if (good_cnt != LOCK_V) good_cnt <= good_cnt + 4'd1;
            locked <= (good_cnt >= LOCK_V - 4'd1);
          end else begin
            good_cnt <= '0;
            locked   <= 1'b0;
            err      <= 1'b1;
            err_cnt  <= err_inc(err_cnt);
          end
        end
      end else if (timeout_hit) begin
        timeout    <= 1'b1;
        err        <= 1'b1;
        err_cnt    <= err_inc(err_cnt);
        locked     <= 1'b0;
        good_cnt   <= '0;
        period_cnt <= '0;
        high_cnt   <= '0;
      end else begin
        period_cnt <= sat_inc(period_cnt, 1'b1);
        high_cnt   <= sat_inc(high_cnt, s);
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: a default instance and one expecting two high samples,
// both fed the same divided-clock pattern; each scenario checks only the relevant instance.
module tb_clk_div_monitor;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sig;

  logic [7:0] per_a, high_a, ecnt_a;
  logic       mv_a, lock_a, err_a, to_a;
  logic [7:0] per_b, high_b, ecnt_b;
  logic       mv_b, lock_b, err_b, to_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Event counters collected after every clock.
  int mv_cnt_a, err_cnt_a, mv_cnt_b, err_cnt_b;
  int to_seen_a;
  int last_per_a, last_high_a, last_per_b, last_high_b;

  clk_div_monitor dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig),
    .period_out(per_a), .high_out(high_a), .meas_valid(mv_a), .locked(lock_a),
    .err(err_a), .timeout(to_a), .err_cnt(ecnt_a)
  );

  clk_div_monitor #(.EXP_HIGH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig),
    .period_out(per_b), .high_out(high_b), .meas_valid(mv_b), .locked(lock_b),
    .err(err_b), .timeout(to_b), .err_cnt(ecnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mv_cnt_a = 0; err_cnt_a = 0; mv_cnt_b = 0; err_cnt_b = 0; to_seen_a = 0;
    last_per_a = 0; last_high_a = 0; last_per_b = 0; last_high_b = 0;
  endtask

  task automatic cyc(input logic v);
    sig = v;
    @(posedge clk);
    #1;
    if (mv_a) begin mv_cnt_a++; last_per_a = per_a; last_high_a = high_a; end
    if (mv_b) begin mv_cnt_b++; last_per_b = per_b; last_high_b = high_b; end
    if (err_a) err_cnt_a++;
    if (err_b) err_cnt_b++;
    if (to_a) to_seen_a = 1;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    cyc(1'b0);
    clear_mon();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    sig   = 1'b0;
    release_rst();
  endtask

  task automatic reps(input int n, input int len, input int highs);
    for (int r = 0; r < n; r++)
      for (int k = 0; k < len; k++) cyc(k < highs);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sig = 1'b0;
    clear_mon();
    #12;
    check("rst_period", per_a, 0);
    check("rst_high", high_a, 0);
    check("rst_outs", {mv_a, lock_a, err_a, to_a}, 0);
    check("rst_errcnt", ecnt_a, 0);
    release_rst();

    // 1: 1,0,0 on the default instance
    reps(4, 3, 1);
    check("t1_mv_after3", mv_cnt_a, 3);
    check("t1_unlocked_after3", lock_a, 0);
    cyc(1'b1);
    check("t1_mv_pulse", mv_a, 1);
    check("t1_locked", lock_a, 1);
    cyc(1'b0);
    check("t1_mv_one_cycle", mv_a, 0);
    cyc(1'b0);
    check("t1_mv_total", mv_cnt_a, 4);
    check("t1_period", last_per_a, 3);
    check("t1_high", last_high_a, 1);
    check("t1_err_none", err_cnt_a + ecnt_a, 0);

    // 2: 1,1,0 on the two-high instance, one long period injected
    do_reset();
    reps(5, 3, 2);
    check("t2_locked", lock_b, 1);
    check("t2_high", last_high_b, 2);
    check("t2_period", last_per_b, 3);
    reps(1, 4, 3);
    cyc(1'b1);
    check("t2_bad_err", err_b, 1);
    check("t2_bad_mv", mv_b, 1);
    check("t2_bad_period", per_b, 4);
    check("t2_bad_high", high_b, 3);
    check("t2_bad_unlock", lock_b, 0);
    check("t2_bad_errcnt", ecnt_b, 1);
    cyc(1'b1); cyc(1'b0);
    reps(3, 3, 2);
    check("t2_not_yet", lock_b, 0);
    reps(1, 3, 2);
    check("t2_relock", lock_b, 1);
    check("t2_errcnt_held", ecnt_b, 1);

    // 3: stuck high after lock
    do_reset();
    reps(5, 3, 1);
    check("t3_locked", lock_a, 1);
    repeat (16) cyc(1'b1);
    check("t3_no_to_yet", to_a, 0);
    cyc(1'b1);
    check("t3_timeout", to_a, 1);
    check("t3_err_pulse", err_a, 1);
    check("t3_unlock", lock_a, 0);
    check("t3_errcnt", ecnt_a, 1);
    repeat (3) cyc(1'b1);
    check("t3_to_held", to_a, 1);
    check("t3_err_once", err_cnt_a, 1);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    check("t3_to_before_rise", to_a, 1);
    cyc(1'b1);
    check("t3_to_cleared", to_a, 0);

    // 4: period equal to the timeout threshold
    do_reset();
    reps(3, 16, 1);
    cyc(1'b1);
    check("t4_mv", mv_cnt_a, 3);
    check("t4_period", last_per_a, 16);
    check("t4_high", last_high_a, 1);
    check("t4_no_timeout", to_seen_a, 0);
    check("t4_errs", err_cnt_a, 3);
    check("t4_errcnt", ecnt_a, 3);

    // 5: enable dropped mid-period
    do_reset();
    reps(5, 3, 1);
    cyc(1'b1); cyc(1'b0);
    check("t5_locked", lock_a, 1);
    check("t5_mv_before", mv_cnt_a, 5);
    en = 1'b0;
    cyc(1'b0);
    check("t5_unlock", lock_a, 0);
    cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b1); cyc(1'b0);
    check("t5_no_mv_idle", mv_cnt_a, 5);
    en = 1'b1;
    cyc(1'b0);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    check("t5_no_mv_first_rise", mv_cnt_a, 5);
    cyc(1'b1);
    check("t5_mv_second_rise", mv_cnt_a, 6);
    check("t5_period", per_a, 3);

    // 6: async reset while locked, then an error burst
    do_reset();
    reps(1, 4, 1);
    reps(5, 3, 1);
    cyc(1'b1); cyc(1'b0);
    check("t6_locked", lock_a, 1);
    check("t6_errcnt_pre", ecnt_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_lock", lock_a, 0);
    check("t6_async_errcnt", ecnt_a, 0);
    check("t6_async_period", per_a, 0);
    check("t6_async_high", high_a, 0);
    check("t6_async_flags", {mv_a, err_a, to_a}, 0);
    release_rst();
    reps(300, 4, 1);
    check("t6_burst_errs", err_cnt_a, 299);
    check("t6_errcnt_sat", ecnt_a, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
